// File: rtl/register_bank_param_if.sv
// Register bank bus: two combinational read ports, one write port,
// soft-clear request and the ready / write-drop status flags.
// The core side uses the master modport, the bank uses the slave modport.
interface register_bank_param_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clr;
    logic              ready;
    logic              wrDrop;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [ADDR_W-1:0] writeReg;
    logic              regWrite;
    logic [DATA_W-1:0] writeData;

    modport master (
        output clr,
        output readReg1,
        output readReg2,
        output writeReg,
        output regWrite,
        output writeData,
        input  ready,
        input  wrDrop,
        input  readData1,
        input  readData2
    );

    modport slave (
        input  clr,
        input  readReg1,
        input  readReg2,
        input  writeReg,
        input  regWrite,
        input  writeData,
        output ready,
        output wrDrop,
        output readData1,
        output readData2
    );
endinterface

// File: rtl/register_bank_param.sv
// Parametrised general-purpose register bank with two combinational read
// ports, one synchronous write port and a sequential init engine that
// loads every entry (one per cycle) after reset or a soft clear.
// Optional same-cycle write-to-read forwarding is enabled by defining the
// macro REGBANK_BYPASS_EN; without it reads return the pre-write contents.
// Reset rst_n is synchronous and active-high despite its name.
module register_bank_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 32,
    parameter int ZERO_REG  = 1,
    parameter int INIT_MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_bank_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    // One extra bit so the range test also works when DEPTH is a power of 2
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam bit                HAS_ZERO  = (ZERO_REG != 0);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] next_cnt;
    logic              wr_drop_q;
    logic              drop_next;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    logic [DATA_W-1:0] regs [DEPTH];

    logic              ready;
    logic              wr_in_range;
    logic              wr_zero;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return ({1'b0, idx} < DEPTH_EXT);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
        return HAS_ZERO && (idx == '0);
    endfunction

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        if (INIT_MODE == 1)
            return DATA_W'(idx);
        else
            return '0;
    endfunction

    assign ready       = (state == READY);
    assign wr_in_range = in_range(bus.writeReg);
    assign wr_zero     = is_zero_reg(bus.writeReg);

    // Next-state logic: init sweep, soft clear and user write arbitration
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        drop_next  = 1'b0;
        arr_we     = 1'b0;
        arr_waddr  = '0;
        arr_wdata  = '0;
        if (bus.clr) begin
            next_state = INIT;
            next_cnt   = '0;
            drop_next  = bus.regWrite;
        end else begin
            case (state)
                INIT: begin
                    arr_we    = 1'b1;
                    arr_waddr = cnt;
                    arr_wdata = init_value(cnt);
                    drop_next = bus.regWrite;
                    if (cnt == LAST_IDX) begin
                        next_state = READY;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.regWrite) begin
                        if (!wr_in_range) begin
                            drop_next = 1'b1;
                        end else if (!wr_zero) begin
                            arr_we    = 1'b1;
                            arr_waddr = bus.writeReg;
                            arr_wdata = bus.writeData;
                        end
                    end
                end
                default: begin
                    next_state = INIT;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Control state register; reset restarts the init sweep from entry 0
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            wr_drop_q <= drop_next;
        end
    end

    // Storage array has no reset of its own and is left untouched during reset
    always_ff @(posedge clk) begin
        if (!rst_n && arr_we) begin
            regs[arr_waddr] <= arr_wdata;
        end
    end

`ifdef REGBANK_BYPASS_EN
    logic bypass_ok;
    assign bypass_ok = ready && bus.regWrite && !bus.clr && wr_in_range && !wr_zero;
`endif

    // Read port 1: masked while not ready, for the zero register and out of range
    always_comb begin
        rd1 = '0;
        if (ready && in_range(bus.readReg1) && !is_zero_reg(bus.readReg1)) begin
            rd1 = regs[bus.readReg1];
        end
`ifdef REGBANK_BYPASS_EN
        if (bypass_ok && (bus.readReg1 == bus.writeReg)) begin
            rd1 = bus.writeData;
        end
`endif
    end

    // Read port 2: identical masking and forwarding rules as port 1
    always_comb begin
        rd2 = '0;
        if (ready && in_range(bus.readReg2) && !is_zero_reg(bus.readReg2)) begin
            rd2 = regs[bus.readReg2];
        end
`ifdef REGBANK_BYPASS_EN
        if (bypass_ok && (bus.readReg2 == bus.writeReg)) begin
            rd2 = bus.writeData;
        end
`endif
    end

    assign bus.ready     = ready;
    assign bus.wrDrop    = wr_drop_q;
    assign bus.readData1 = rd1;
    assign bus.readData2 = rd2;

endmodule

// File: tb/tb_register_bank_param.sv
// Self-checking bench for register_bank_param (DEPTH=32, DATA_W=32,
// ZERO_REG=1, INIT_MODE=1). Expectations follow REGBANK_BYPASS_EN.
module tb_register_bank_param;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    register_bank_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    register_bank_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (1),
        .INIT_MODE(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: ready flag, edges left until ready, stored contents
    bit          m_ready     = 1'b0;
    int          m_remaining = DEPTH;
    logic [31:0] m_mem [DEPTH];
    logic        m_drop      = 1'b0;

    typedef struct {
        logic        clr;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        erdy;
        logic        edrop;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (!m_ready) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (BYP && bus.regWrite && !bus.clr && bus.writeReg != 5'd0 && a == bus.writeReg)
            return bus.writeData;
        return m_mem[a];
    endfunction

    task automatic modelStep();
        if (rst_n) begin
            m_ready     = 1'b0;
            m_remaining = DEPTH;
            m_drop      = 1'b0;
        end else if (bus.clr) begin
            m_drop      = bus.regWrite;
            m_ready     = 1'b0;
            m_remaining = DEPTH;
        end else if (!m_ready) begin
            m_drop = bus.regWrite;
            m_remaining--;
            if (m_remaining == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'(i);
            end
        end else begin
            m_drop = 1'b0;
            if (bus.regWrite && bus.writeReg != 5'd0) m_mem[bus.writeReg] = bus.writeData;
        end
    endtask

    // One clock cycle: drive, check reads before the edge, check flags after
    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 output logic [31:0] o1, output logic [31:0] o2,
                                 output logic ordy, output logic odrop);
        @(negedge clk);
        rst_n         = r;
        bus.clr       = c;
        bus.regWrite  = w;
        bus.writeReg  = wr;
        bus.writeData = wd;
        bus.readReg1  = a1;
        bus.readReg2  = a2;
        #1;
        o1 = bus.readData1;
        o2 = bus.readData2;
        checkOutput("model_rd1", o1, modelRead(a1));
        checkOutput("model_rd2", o2, modelRead(a2));
        @(posedge clk);
        modelStep();
        #1;
        ordy  = bus.ready;
        odrop = bus.wrDrop;
        checkOutput("model_ready", {31'd0, ordy}, {31'd0, m_ready});
        checkOutput("model_drop", {31'd0, odrop}, {31'd0, m_drop});
    endtask

    task automatic idle(output logic ordy);
        logic [31:0] d1, d2;
        logic        dd;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, d1, d2, ordy, dd);
    endtask

    logic [31:0] o1, o2;
    logic        ordy, odrop;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd8,
                    (BYP ? 32'hDEADBEEF : 32'd7), 32'd8, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 5'd0,  32'd0, 5'd7,  5'd0,
                    32'hDEADBEEF, 32'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  32'h1234, 5'd0,  5'd7,
                    32'd0, 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 5'd0,  32'd0, 5'd0,  5'd1,
                    32'd0, 32'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd12, 32'h55, 5'd12, 5'd12,
                    (BYP ? 32'h55 : 32'd12), (BYP ? 32'h55 : 32'd12), 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 5'd0,  32'd0, 5'd12, 5'd31,
                    32'h55, 32'd31, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd30, 5'd31,
                    32'd30, (BYP ? 32'hFFFFFFFF : 32'd31), 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  32'd0, 5'd31, 5'd12,
                    32'hFFFFFFFF, 32'h55, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 5'd9,  32'hAA, 5'd9,  5'd7,
                    32'd9, 32'hDEADBEEF, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 5'd0,  32'd0, 5'd9,  5'd7,
                    32'd0, 32'd0, 1'b0, 1'b0};

        rst_n = 1'b1;
        bus.clr = 1'b0;
        bus.regWrite = 1'b0;
        bus.writeReg = '0;
        bus.writeData = '0;
        bus.readReg1 = '0;
        bus.readReg2 = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        @(posedge clk);

        $display("[TB] reset and init sweep");
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, o1, o2, ordy, odrop);
        checkOutput("reset_ready", {31'd0, ordy}, 32'd0);
        checkOutput("reset_drop", {31'd0, odrop}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(ordy);
            checkOutput($sformatf("init_ready_%0d", i), {31'd0, ordy}, {31'd0, (i == DEPTH)});
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, o1, o2, ordy, odrop);
        checkOutput("init_reg5", o1, 32'd5);
        checkOutput("init_reg31", o2, 32'd31);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd31, o1, o2, ordy, odrop);
        checkOutput("init_reg0", o1, 32'd0);

        $display("[TB] vector table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(1'b0, vecs[v].clr, vecs[v].we, vecs[v].wr, vecs[v].wd,
                          vecs[v].a1, vecs[v].a2, o1, o2, ordy, odrop);
            checkOutput($sformatf("vec%0d_rd1", v), o1, vecs[v].e1);
            checkOutput($sformatf("vec%0d_rd2", v), o2, vecs[v].e2);
            checkOutput($sformatf("vec%0d_ready", v), {31'd0, ordy}, {31'd0, vecs[v].erdy});
            checkOutput($sformatf("vec%0d_drop", v), {31'd0, odrop}, {31'd0, vecs[v].edrop});
        end

        $display("[TB] re-init after soft clear");
        for (int i = 1; i <= DEPTH - 1; i++) begin
            idle(ordy);
            checkOutput($sformatf("clr_ready_%0d", i), {31'd0, ordy}, {31'd0, (i == DEPTH - 1)});
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd7, o1, o2, ordy, odrop);
        checkOutput("clr_reg9", o1, 32'd9);
        checkOutput("clr_reg7", o2, 32'd7);

        $display("[TB] write during init and reset mid-init");
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, o1, o2, ordy, odrop);
        checkOutput("clr2_ready", {31'd0, ordy}, 32'd0);
        checkOutput("clr2_drop", {31'd0, odrop}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, (k == 5), 5'd3, 32'h777, 5'd3, 5'd4, o1, o2, ordy, odrop);
            checkOutput($sformatf("mid_rd_%0d", k), o1, 32'd0);
            checkOutput($sformatf("mid_drop_%0d", k), {31'd0, odrop}, {31'd0, (k == 5)});
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 32'h999, 5'd0, 5'd0, o1, o2, ordy, odrop);
        checkOutput("rst_mid_ready", {31'd0, ordy}, 32'd0);
        checkOutput("rst_mid_drop", {31'd0, odrop}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, o1, o2, ordy, odrop);
        for (int i = 1; i <= DEPTH; i++) begin
            idle(ordy);
            checkOutput($sformatf("rst_ready_%0d", i), {31'd0, ordy}, {31'd0, (i == DEPTH)});
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd10, o1, o2, ordy, odrop);
        checkOutput("rst_reg3", o1, 32'd3);
        checkOutput("rst_reg10", o2, 32'd10);

        $display("[TB] randomized traffic against reference model");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 79) == 0), ($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                          5'($urandom), 5'($urandom), o1, o2, ordy, odrop);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
